// File: rtl/onchip_mem_cmd_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_cmd_stage_if
//  Purpose  : Avalon-MM slave-side bundle for the on-chip RAM command stage.
//             master modport = the Nios II data master / interconnect side,
//             slave modport  = the command stage itself.
//  Revision : 1.0  initial release
// ============================================================================
interface onchip_mem_cmd_stage_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_write;
    logic [BE_W-1:0]   s_byteenable;
    logic [DATA_W-1:0] s_writedata;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;

    modport master (
        output s_address, s_read, s_write, s_byteenable, s_writedata,
        input  s_waitrequest, s_readdata, s_readdatavalid
    );

    modport slave (
        input  s_address, s_read, s_write, s_byteenable, s_writedata,
        output s_waitrequest, s_readdata, s_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/onchip_mem_cmd_stage.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_cmd_stage
//  Purpose  : Registered Avalon-MM command stage in front of a single-port
//             on-chip RAM. Issues one registered RAM command per cycle,
//             returns read data with a fixed latency of 2, and contains a
//             clear engine that writes a pattern into every RAM word.
//  Revision : 1.0  initial release
// ============================================================================
module onchip_mem_cmd_stage #(
    parameter int  ADDR_W         = 11,
    parameter int  DATA_W         = 32,
    parameter int  CLEAR_ON_RESET = 0,
    localparam int BE_W           = DATA_W / 8
) (
    input  wire logic              clk,
    input  wire logic              reset_n,

    onchip_mem_cmd_stage_if.slave  s,

    input  wire logic              clear_start,
    input  wire logic [DATA_W-1:0] clear_value,
    output logic                   busy,
    output logic                   clear_done,

    output logic [ADDR_W-1:0]      m_address,
    output logic [BE_W-1:0]        m_byteenable,
    output logic                   m_chipselect,
    output logic                   m_write,
    output logic [DATA_W-1:0]      m_writedata,
    output logic                   m_clken,
    input  wire logic [DATA_W-1:0] m_readdata
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t          c_reset_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [BE_W-1:0] c_be_all      = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clear_cnt;
    logic [DATA_W-1:0] r_clear_pat;

    // Command register presented directly to the RAM
    logic [ADDR_W-1:0] r_addr;
    logic [BE_W-1:0]   r_be;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cs;
    logic              r_wr;

    // Read tracking: r_rd_pend marks a read sitting in the command register,
    // r_rdv marks the cycle the RAM q output carries its data.
    logic              r_rd_pend;
    logic              r_rdv;
    logic              r_done;

    logic              w_accept;
    logic              w_last_beat;

    assign w_accept    = (r_state == ST_RUN) && (s.s_read || s.s_write);
    assign w_last_beat = &r_clear_cnt;

    // Single state machine: command register, clear engine and read pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_reset_state;
            r_clear_cnt <= '0;
            r_clear_pat <= '0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_cs        <= 1'b0;
            r_wr        <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rdv       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Idle command register unless something below loads it
            r_cs      <= 1'b0;
            r_wr      <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rdv     <= r_rd_pend;
            r_done    <= 1'b0;

            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        r_addr    <= s.s_address;
                        r_be      <= s.s_byteenable;
                        r_wdata   <= s.s_writedata;
                        r_wr      <= s.s_write;
                        r_cs      <= 1'b1;
                        // Simultaneous read+write is treated as a write only
                        r_rd_pend <= s.s_read & ~s.s_write;
                    end
                    // A command accepted on this same edge still issues above
                    if (clear_start) begin
                        r_state     <= ST_CLEAR;
                        r_clear_pat <= clear_value;
                        r_clear_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_addr      <= r_clear_cnt;
                    r_be        <= c_be_all;
                    r_wdata     <= r_clear_pat;
                    r_wr        <= 1'b1;
                    r_cs        <= 1'b1;
                    r_clear_cnt <= r_clear_cnt + 1'b1;
                    if (w_last_beat) begin
                        r_state <= ST_RUN;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign s.s_waitrequest   = (r_state != ST_RUN);
    assign s.s_readdata      = m_readdata;
    assign s.s_readdatavalid = r_rdv;

    assign busy         = (r_state == ST_CLEAR);
    assign clear_done   = r_done;

    assign m_address    = r_addr;
    assign m_byteenable = r_be;
    assign m_chipselect = r_cs;
    assign m_write      = r_wr;
    assign m_writedata  = r_wdata;
    assign m_clken      = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_cmd_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onchip_mem_cmd_stage
//  Purpose  : Self-checking bench for onchip_mem_cmd_stage. Two instances
//             share the master command inputs: u_dut1 clears on reset,
//             u_dut0 starts in RUN. Each has its own RAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_onchip_mem_cmd_stage;

    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, rst0_n;
    logic        cmd_read, cmd_write;
    logic [10:0] cmd_addr;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic        cs_start1, cs_start0;
    logic [31:0] cs_val1, cs_val0;
    logic        busy1, done1, busy0, done0;
    logic [10:0] m_addr1, m_addr0;
    logic [3:0]  m_be1, m_be0;
    logic        m_cs1, m_cs0, m_wr1, m_wr0, m_ck1, m_ck0;
    logic [31:0] m_wd1, m_wd0, q1, q0;

    onchip_mem_cmd_stage_if #(.ADDR_W(11), .DATA_W(32)) bus1 ();
    onchip_mem_cmd_stage_if #(.ADDR_W(11), .DATA_W(32)) bus0 ();

    assign bus1.s_address    = cmd_addr;
    assign bus1.s_read       = cmd_read;
    assign bus1.s_write      = cmd_write;
    assign bus1.s_byteenable = cmd_be;
    assign bus1.s_writedata  = cmd_wdata;
    assign bus0.s_address    = cmd_addr;
    assign bus0.s_read       = cmd_read;
    assign bus0.s_write      = cmd_write;
    assign bus0.s_byteenable = cmd_be;
    assign bus0.s_writedata  = cmd_wdata;

    onchip_mem_cmd_stage #(.ADDR_W(11), .DATA_W(32), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .reset_n(rst1_n), .s(bus1.slave),
        .clear_start(cs_start1), .clear_value(cs_val1), .busy(busy1), .clear_done(done1),
        .m_address(m_addr1), .m_byteenable(m_be1), .m_chipselect(m_cs1), .m_write(m_wr1),
        .m_writedata(m_wd1), .m_clken(m_ck1), .m_readdata(q1)
    );

    onchip_mem_cmd_stage #(.ADDR_W(11), .DATA_W(32), .CLEAR_ON_RESET(0)) u_dut0 (
        .clk(clk), .reset_n(rst0_n), .s(bus0.slave),
        .clear_start(cs_start0), .clear_value(cs_val0), .busy(busy0), .clear_done(done0),
        .m_address(m_addr0), .m_byteenable(m_be0), .m_chipselect(m_cs0), .m_write(m_wr0),
        .m_writedata(m_wd0), .m_clken(m_ck0), .m_readdata(q0)
    );

    // Single-port RAM models: q is registered one edge after the command
    logic [31:0] ram1 [DEPTH];
    logic [31:0] ram0 [DEPTH];

    always @(posedge clk) begin
        if (m_cs1) begin
            if (m_wr1) begin
                for (int b = 0; b < 4; b++)
                    if (m_be1[b]) ram1[m_addr1][8*b +: 8] <= m_wd1[8*b +: 8];
            end else begin
                q1 <= ram1[m_addr1];
            end
        end
    end

    always @(posedge clk) begin
        if (m_cs0) begin
            if (m_wr0) begin
                for (int b = 0; b < 4; b++)
                    if (m_be0[b]) ram0[m_addr0][8*b +: 8] <= m_wd0[8*b +: 8];
            end else begin
                q0 <= ram0[m_addr0];
            end
        end
    end

    // Edge counter and read-response capture (sampled on the falling edge)
    int          cyc = 0;
    logic [31:0] rq1 [$];
    logic [31:0] rq0 [$];
    int          rc1 [$];
    int          rc0 [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus1.s_readdatavalid) begin
            rq1.push_back(bus1.s_readdata);
            rc1.push_back(cyc);
        end
        if (bus0.s_readdatavalid) begin
            rq0.push_back(bus0.s_readdata);
            rc0.push_back(cyc);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [10:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rsp;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input string name, input logic rd, input logic wr,
                           input logic [10:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic rsp, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.be = be;
        v.wdata = wdata; v.rsp = rsp; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One command on the selected instance; checks response count, data, latency
    task automatic do_vec(input bit sel, input vec_t v);
        int base, acc, sz;
        base = sel ? rq1.size() : rq0.size();
        @(negedge clk);
        chk({v.name, " ready"}, sel ? bus1.s_waitrequest : bus0.s_waitrequest, 0);
        cmd_read  = v.rd;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_be    = v.be;
        cmd_wdata = v.wdata;
        @(posedge clk);
        #1;
        acc       = cyc;
        cmd_read  = 1'b0;
        cmd_write = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        sz = (sel ? rq1.size() : rq0.size()) - base;
        chk({v.name, " rsp count"}, sz, v.rsp ? 1 : 0);
        if (v.rsp && sz >= 1) begin
            chk({v.name, " data"}, sel ? rq1[base] : rq0[base], v.exp);
            chk({v.name, " latency"}, (sel ? rc1[base] : rc0[base]) - acc + 1, 2);
        end
    endtask

    // Observes a full clear on u_dut1, starting at the current falling edge
    task automatic watch_clear(input string name, input int restart_at, input logic [31:0] pat);
        int n_wait, n_beat, n_bad, n_done;
        n_wait = 0; n_beat = 0; n_bad = 0; n_done = 0;
        for (int i = 0; i < 2060; i++) begin
            if (bus1.s_waitrequest) n_wait++;
            if (done1) n_done++;
            if (m_cs1 && m_wr1) begin
                if (m_addr1 !== n_beat[10:0] || m_wd1 !== pat || m_be1 !== 4'hF) n_bad++;
                n_beat++;
            end
            cs_start1 = (i == restart_at);
            @(negedge clk);
        end
        cs_start1 = 1'b0;
        chk({name, " waitrequest cycles"}, n_wait, 2048);
        chk({name, " beats"}, n_beat, 2048);
        chk({name, " bad beats"}, n_bad, 0);
        chk({name, " clear_done pulses"}, n_done, 1);
        chk({name, " busy after"}, busy1, 0);
        chk({name, " waitrequest after"}, bus1.s_waitrequest, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base, acc0, n_d;
        int   acc [4];
        vec_t v;

        rst1_n = 1'b0; rst0_n = 1'b0;
        cmd_read = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_be = '0; cmd_wdata = '0;
        cs_start1 = 1'b0; cs_start0 = 1'b0; cs_val1 = '0; cs_val0 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst1 chipselect", m_cs1, 0);
        chk("rst1 write", m_wr1, 0);
        chk("rst1 address", m_addr1, 0);
        chk("rst1 writedata", m_wd1, 0);
        chk("rst1 byteenable", m_be1, 0);
        chk("rst1 readdatavalid", bus1.s_readdatavalid, 0);
        chk("rst1 clear_done", done1, 0);
        chk("rst1 busy", busy1, 1);
        chk("rst1 waitrequest", bus1.s_waitrequest, 1);
        chk("rst1 clken", m_ck1, 1);
        chk("rst0 busy", busy0, 0);
        chk("rst0 waitrequest", bus0.s_waitrequest, 0);
        chk("rst0 chipselect", m_cs0, 0);

        // Clear-on-reset fill with zero
        rst1_n = 1'b1; rst0_n = 1'b1;
        watch_clear("init clear", -1, 32'h0);

        // Table-driven single commands on u_dut1
        add_vec("rd 005",       1, 0, 11'h005, 4'hF, 32'h0,        1, 32'h0000_0000);
        add_vec("wr 010 full",  0, 1, 11'h010, 4'hF, 32'hDEADBEEF, 0, 32'h0);
        add_vec("wr 010 low",   0, 1, 11'h010, 4'h3, 32'h00001234, 0, 32'h0);
        add_vec("rd 010",       1, 0, 11'h010, 4'hF, 32'h0,        1, 32'hDEAD1234);
        add_vec("wr 000",       0, 1, 11'h000, 4'hF, 32'h11,       0, 32'h0);
        add_vec("wr 001",       0, 1, 11'h001, 4'hF, 32'h22,       0, 32'h0);
        add_vec("wr 002",       0, 1, 11'h002, 4'hF, 32'h33,       0, 32'h0);
        add_vec("wr 003",       0, 1, 11'h003, 4'hF, 32'h44,       0, 32'h0);
        add_vec("rd 002",       1, 0, 11'h002, 4'hF, 32'h0,        1, 32'h33);
        add_vec("rd+wr 020",    1, 1, 11'h020, 4'hF, 32'h55,       0, 32'h0);
        add_vec("rd 020",       1, 0, 11'h020, 4'hF, 32'h0,        1, 32'h55);
        add_vec("wr 7ff byte3", 0, 1, 11'h7FF, 4'h8, 32'hFF000000, 0, 32'h0);
        add_vec("rd 7ff",       1, 0, 11'h7FF, 4'hF, 32'h0,        1, 32'hFF000000);
        add_vec("rd 7fe",       1, 0, 11'h7FE, 4'hF, 32'h0,        1, 32'h0);
        foreach (vecs[i]) do_vec(1'b1, vecs[i]);

        // Back-to-back reads of 0..3
        base = rq1.size();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cmd_read = 1'b1;
            cmd_addr = i[10:0];
            @(posedge clk);
            #1;
            acc[i] = cyc;
        end
        cmd_read = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("b2b rsp count", rq1.size() - base, 4);
        for (int i = 0; i < 4 && base + i < rq1.size(); i++) begin
            chk($sformatf("b2b data %0d", i), rq1[base+i], 32'h11 * (i + 1));
            chk($sformatf("b2b cycle %0d", i), rc1[base+i] - acc[0], i + 1);
        end

        // Clear started on the same edge as a read of 0x010
        base = rq1.size();
        @(negedge clk);
        cmd_read = 1'b1; cmd_addr = 11'h010;
        cs_start1 = 1'b1; cs_val1 = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        acc0 = cyc;
        cmd_read = 1'b0; cs_start1 = 1'b0;
        @(negedge clk);
        watch_clear("clear A5", -1, 32'hA5A5A5A5);
        chk("clear-edge rd count", rq1.size() - base, 1);
        if (rq1.size() > base) begin
            chk("clear-edge rd data", rq1[base], 32'hDEAD1234);
            chk("clear-edge rd latency", rc1[base] - acc0 + 1, 2);
        end
        v = '{name: "post-clear rd 000", rd: 1, wr: 0, addr: 11'h000, be: 4'hF, wdata: 0, rsp: 1, exp: 32'hA5A5A5A5};
        do_vec(1'b1, v);
        v.name = "post-clear rd 7ff"; v.addr = 11'h7FF;
        do_vec(1'b1, v);

        // Second clear_start pulse mid-clear is ignored
        @(negedge clk);
        cs_start1 = 1'b1; cs_val1 = 32'h3C3C3C3C;
        @(posedge clk);
        #1;
        cs_start1 = 1'b0;
        @(negedge clk);
        watch_clear("clear restart", 500, 32'h3C3C3C3C);
        v = '{name: "restart rd 100", rd: 1, wr: 0, addr: 11'h100, be: 4'hF, wdata: 0, rsp: 1, exp: 32'h3C3C3C3C};
        do_vec(1'b1, v);

        // u_dut0: reset asserted mid-clear
        v = '{name: "d0 wr 064", rd: 0, wr: 1, addr: 11'h064, be: 4'hF, wdata: 32'hCAFEF00D, rsp: 0, exp: 0};
        do_vec(1'b0, v);
        @(negedge clk);
        cs_start0 = 1'b1; cs_val0 = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        cs_start0 = 1'b0;
        n_d = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done0) n_d++;
        end
        chk("d0 mid-clear busy", busy0, 1);
        chk("d0 mid-clear write", m_wr0, 1);
        rst0_n = 1'b0;
        #1;
        chk("d0 abort chipselect", m_cs0, 0);
        chk("d0 abort write", m_wr0, 0);
        chk("d0 abort address", m_addr0, 0);
        chk("d0 abort writedata", m_wd0, 0);
        chk("d0 abort busy", busy0, 0);
        chk("d0 abort waitrequest", bus0.s_waitrequest, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done0) n_d++;
        end
        rst0_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done0) n_d++;
        end
        chk("d0 no clear_done", n_d, 0);
        chk("d0 busy after", busy0, 0);
        chk("d0 waitrequest after", bus0.s_waitrequest, 0);
        v = '{name: "d0 rd 064", rd: 1, wr: 0, addr: 11'h064, be: 4'hF, wdata: 0, rsp: 1, exp: 32'hCAFEF00D};
        do_vec(1'b0, v);
        v.name = "d0 rd 000"; v.addr = 11'h000; v.exp = 32'h5A5A5A5A;
        do_vec(1'b0, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
